// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared state type and limits for the request crossing receiver
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } cdc_rx_state_e;

  localparam int CDC_SETTLE_MAX = 15;

endpackage

// File: rtl/cdc_req_rx.sv
// rtl/cdc_req_rx.sv - destination-side receiver for a toggle request/ack bus crossing
module cdc_req_rx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  ack_toggle,
  output logic                  busy,
  output logic                  overrun_err
);

  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > CDC_SETTLE_MAX) begin : g_bad_settle
    $error("cdc_req_rx: SETTLE_CYCLES out of range");
  end

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  cdc_rx_state_e state, state_next;
  logic [3:0]    settle_cnt, settle_next;
  logic          req_prev;
  logic          toggle_det;
  logic          capture;
  logic          handshake;

  assign toggle_det = req_sync ^ req_prev;

  // Next-state: a toggle seen outside IDLE is ignored here and only flagged below
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    capture     = 1'b0;
    handshake   = 1'b0;
    case (state)
      IDLE: begin
        if (toggle_det) begin
          settle_next = SETTLE_INIT;
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = VALID;
        end else begin
          settle_next = settle_cnt - 4'd1;
        end
      end
      VALID: begin
        if (out_valid && out_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, edge history and registered output decodes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      settle_cnt  <= 4'd0;
      req_prev    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      ack_toggle  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      req_prev   <= req_sync;
      out_valid  <= (state_next == VALID);
      busy       <= (state_next != IDLE);
      if (capture) begin
        out_data <= xfer_data;
      end
      if (handshake) begin
        ack_toggle <= ~ack_toggle;
      end
      if (toggle_det && state != IDLE) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule
